mux_scan: RTL
=============

# mux_scan

Parametrised N:1 registered multiplexer with a manual-select mode and an automatic channel-scan mode. It generalises the 2:1 combinational mux to WIDTH-bit data and CHANNELS inputs. Auto-scan steps through the channels, dwelling DWELL cycles on each one. It sits between the lab's input-switch or sensor banks and the display/decoder stage, presenting one channel at a time together with its index.

## Interface
- WIDTH, 8: data width of each channel.
- CHANNELS, 4: number of input channels, ≥2.
- DWELL, 2: cycles spent on each channel in scan mode, ≥1.
- SELW (localparam): clog2(CHANNELS), minimum 1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  block enable; when low, all state holds.
- mode  in  1  0 = MANUAL (channel from sel_in), 1 = SCAN (internal counter).
- sel_in  in  SELW  channel select used in MANUAL mode.
- din  in  CHANNELS*WIDTH  packed inputs; channel k is din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- sel_out  out  SELW  index of the channel currently in dout.
- valid  out  1  dout/sel_out were updated on the last edge.
- wrap  out  1  one-cycle pulse when scan advances from CHANNELS-1 to 0.

## Operation
- States: IDLE (en=0), MANUAL (en=1, mode=0), SCAN (en=1, mode=1).
  - The state is a registered copy of {en, mode}.
  - Transitions take effect on the edge where the inputs are sampled.
- IDLE:
  - dout, sel_out and the dwell counter hold.
  - valid=0, wrap=0.
- MANUAL, sel_in < CHANNELS:
  - sel_out <= sel_in; dout <= channel sel_in; valid <= 1.
  - Dwell counter is cleared to 0.
- MANUAL, sel_in ≥ CHANNELS (non-power-of-2 CHANNELS only):
  - dout and sel_out hold; valid <= 0.
- SCAN:
  - dout <= channel sel_out every cycle, so live data on the dwelled channel is tracked; valid <= 1.
  - Dwell counter runs 0..DWELL-1.
  - When the counter is at DWELL-1 it returns to 0 and sel_out advances by 1.
  - At CHANNELS-1, sel_out advances to 0 and wrap <= 1 for one cycle.
- MANUAL→SCAN: scan starts at the current sel_out with the dwell counter at 0. No channel is skipped.
- SCAN→MANUAL: the sel_in value sampled on the switching edge is used. The dwell counter is cleared.
- en deasserted mid-dwell: the counter freezes and resumes at the same count when en returns with mode=1.
- Arithmetic:
  - Dwell counter width is clog2(DWELL), minimum 1.
  - Channel increment wraps modulo CHANNELS, never modulo 2^SELW.

## Timing
- Latency: 1 cycle from din/sel_in to dout/sel_out. There is no combinational path from inputs to outputs.
- Reset values: dout=0, sel_out=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
- Reset asserted mid-scan: outputs clear asynchronously. After release, the scan restarts at channel 0 with a full DWELL.
- In SCAN, each channel is presented for exactly DWELL consecutive enabled cycles.
  - Full rotation = CHANNELS*DWELL enabled cycles.
  - wrap is high on the first cycle channel 0 is presented after channel CHANNELS-1.
- DWELL=1: sel_out changes every enabled cycle.
- Changing mode and sel_in on the same edge: the new mode governs that edge.

## Structure
- Shared package mux_scan_pkg holds:
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1;
  - state encoding IDLE/MANUAL/SCAN;
  - a clog2 helper function used for SELW and the dwell-counter width.
- One sub-module, scan_counter, contains the dwell counter plus channel index with modulo-CHANNELS wrap and the wrap pulse.
  - Ports: clk, reset, en, clear, load, load_val → idx, wrap.
- The top level holds the state register, the output registers and the data slice select.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, DWELL=2, din={8'h44,8'h33,8'h22,8'h11}.
- Reset then MANUAL, sel_in=2 → next edge: dout=8'h33, sel_out=2, valid=1. While reset is high, all outputs read 0.
- SCAN from reset for 10 enabled cycles → sel_out sequence 0,0,1,1,2,2,3,3,0,0; dout follows 11,11,22,22,33,33,44,44,11,11; wrap=1 only on the 9th output cycle.
- SCAN, drop en after the first cycle on channel 1 for 3 cycles, then restore → valid=0 and outputs hold during the gap; channel 1 is then shown for one more cycle before advancing to 2.
- MANUAL sel_in=3, then switch to SCAN → sel_out shows 3 for two cycles, then 0 with wrap=1.
- SCAN on channel 2, change din channel 2 to 8'hAA mid-dwell → dout=8'hAA on the next edge, sel_out stays 2.
- Assert reset asynchronously between edges during SCAN → outputs go to 0 before the next clock edge; after release, the scan restarts at channel 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan block: mode constants, state encoding
// and the width helper used to size select and dwell-counter fields.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Encoding mirrors the sampled {en, mode} pair; en low collapses to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b10,
    SCAN   = 2'b11
  } state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < value) begin
        bits = b + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter plus channel index for auto-scan; the index wraps modulo
// CHANNELS and flags the step from the last channel back to channel 0.
module scan_counter
  import mux_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SELW    = clog2_min1(CHANNELS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clear,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  output logic [SELW-1:0] idx,
  output logic            wrap
);

  localparam int CNTW = clog2_min1(DWELL);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] idx_q, idx_d;
  logic            wrap_q, wrap_d;

  // wrap stays set while disabled so a pending wrap survives an enable gap.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wrap_d = wrap_q;
    if (en) begin
      wrap_d = 1'b0;
      if (load) begin
        idx_d = load_val;
        cnt_d = '0;
      end else if (clear) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 multiplexer with manual channel select and an automatic
// scan that dwells DWELL enabled cycles on each channel.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SELW    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           sel_out,
  output logic                      valid,
  output logic                      wrap
);

  localparam logic [SELW:0] CH_COUNT = (SELW + 1)'(CHANNELS);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [SELW-1:0]   sel_out_q, sel_out_d;
  logic              sel_ok_q, sel_ok_d;
  logic              wrap_q, wrap_d;
  logic              sel_in_ok;
  logic              cnt_clear, cnt_load;
  logic [SELW-1:0]   scan_idx;
  logic              scan_wrap;

  assign sel_in_ok = ({1'b0, sel_in} < CH_COUNT);

  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = (mode == MODE_MANUAL) ? MANUAL : SCAN;
    end
  end

  // The freshly sampled mode governs the edge, hence the case on state_d.
  always_comb begin
    dout_d    = dout_q;
    sel_out_d = sel_out_q;
    sel_ok_d  = 1'b0;
    wrap_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    case (state_d)
      MANUAL: begin
        sel_ok_d = sel_in_ok;
        if (sel_in_ok) begin
          dout_d    = din[int'(sel_in)*WIDTH +: WIDTH];
          sel_out_d = sel_in;
          cnt_load  = 1'b1;
        end else begin
          cnt_clear = 1'b1;
        end
      end
      SCAN: begin
        dout_d    = din[int'(scan_idx)*WIDTH +: WIDTH];
        sel_out_d = scan_idx;
        wrap_d    = scan_wrap;
      end
      default: begin
      end
    endcase
  end

  // Loading sel_in in MANUAL keeps the scan index equal to sel_out, so a
  // later switch to SCAN starts on the channel already shown.
  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (sel_in),
    .idx      (scan_idx),
    .wrap     (scan_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dout_q    <= '0;
      sel_out_q <= '0;
      sel_ok_q  <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      sel_out_q <= sel_out_d;
      sel_ok_q  <= sel_ok_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dout    = dout_q;
  assign sel_out = sel_out_q;
  assign valid   = (state_q == SCAN) || ((state_q == MANUAL) && sel_ok_q);
  assign wrap    = wrap_q;

endmodule
